uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, number of byte entries (power of two, 2..256).
REQ-002 The block SHALL have parameter AW, default 4, pointer width, equal to log2(DEPTH).
REQ-003 The block SHALL have parameter THRESH, default 8, fill level at or above which irq asserts (1..DEPTH).
REQ-004 Port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port wr_data, input, 8, received byte; driven from the receiver rx_data.
REQ-007 Port wr_en, input, 1, one-cycle write strobe; driven from the receiver rx_done.
REQ-008 Port rd_en, input, 1, read request from the host side.
REQ-009 Port ovr_clr, input, 1, clears the overrun flag.
REQ-010 Port rd_data, output, 8, registered read data.
REQ-011 Port rd_valid, output, 1, one-cycle pulse qualifying rd_data.
REQ-012 Port empty, output, 1, high when count == 0.
REQ-013 Port full, output, 1, high when count == DEPTH.
REQ-014 Port count, output, AW+1, current number of stored bytes.
REQ-015 Port overrun, output, 1, sticky flag: a byte was dropped.
REQ-016 Port irq, output, 1, high when count >= THRESH.

Function
REQ-017 Storage SHALL be a DEPTH x 8 circular buffer with AW-bit write and read pointers that wrap from DEPTH-1 to 0.
REQ-018 Write accepted when wr_en=1 and (full=0 or a read is accepted in the same cycle): byte stored at wr_ptr, wr_ptr increments.
REQ-019 wr_en=1 with full=1 and no accepted read SHALL drop the byte, leave memory, pointers and count unchanged, and set overrun=1 the next cycle.
REQ-020 Read accepted when rd_en=1 and empty=0: rd_data <= mem[rd_ptr], rd_valid=1 the next cycle, rd_ptr increments; latency is exactly one clock.
REQ-021 rd_en=1 with empty=1 SHALL be ignored: rd_valid stays 0, rd_data holds its previous value, no pointer change.
REQ-022 rd_data SHALL hold its last value when no read is accepted; rd_valid is 0 in every cycle not following an accepted read.
REQ-023 Simultaneous accepted write and read SHALL leave count unchanged; both pointers advance.
REQ-024 Simultaneous write and read when full SHALL accept both, with no overrun; read returns the oldest byte.
REQ-025 Simultaneous write and read when empty SHALL accept the write only; read ignored per REQ-021 (no write-through bypass).
REQ-026 count SHALL be a registered up/down counter: +1 write only, -1 read only, unchanged otherwise; never exceeds DEPTH nor underflows.
REQ-027 empty, full and irq SHALL be combinational decodes of registered count, valid in the cycle count updates.
REQ-028 overrun SHALL stay set until ovr_clr=1; ovr_clr clears it the next cycle; simultaneous ovr_clr and a new drop SHALL leave overrun=1 (set wins).
REQ-029 Output ordering SHALL be strict FIFO; no byte is duplicated or reordered across pointer wrap-around.

Reset
REQ-030 rst=1 SHALL asynchronously set wr_ptr=0, rd_ptr=0, count=0, rd_data=8'h00, rd_valid=0, overrun=0; hence empty=1, full=0, irq=0.
REQ-031 Memory contents need not be reset; no stale entry is readable after reset since empty=1.
REQ-032 Reset asserted mid-operation (including during a write/read cycle) SHALL discard all stored bytes and pending strokes; first write after deassertion lands at entry 0.

Verification
REQ-033 Reset, then write 8'hA5, 8'h3C; rd_en on two cycles -> rd_valid pulses with rd_data 8'hA5 then 8'h3C, count 2->1->0, empty=1.
REQ-034 Write 16 bytes 8'h00..8'h0F -> full=1, count=16, irq high from the 8th write; 17th write 8'hFF -> dropped, overrun=1; read all 16 -> 8'h00..8'h0F in order, never 8'hFF.
REQ-035 With count=16, assert wr_en (8'h77) and rd_en together -> no overrun, count stays 16, rd_data=oldest byte, 8'h77 read last.
REQ-036 rd_en with empty=1 -> rd_valid stays 0, rd_data unchanged, count 0; wr_en and rd_en together while empty -> count=1, rd_valid=0.
REQ-037 Stream 40 bytes with interleaved reads keeping count 1..5 -> pointers wrap twice, all 40 bytes out in order, no overrun.
REQ-038 Fill to 10, set overrun, assert rst for one cycle mid-write -> count=0, empty=1, overrun=0, rd_data=8'h00; ovr_clr/drop same cycle test -> overrun remains 1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between a UART receiver and a host reader.
// Registered read port, sticky overrun on dropped bytes, fill-level irq.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int THRESH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic          ovr_clr,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overrun,
    output logic          irq
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_rd_data;
    logic          r_rd_valid;
    logic          r_overrun;

    logic w_rd_acc;
    logic w_wr_acc;
    logic w_drop;

    assign empty = (r_count == '0);
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign irq   = (r_count >= (AW+1)'(THRESH));

    // A read frees a slot in the same cycle, so a full FIFO still accepts a write
    assign w_rd_acc = rd_en & ~empty;
    assign w_wr_acc = wr_en & (~full | w_rd_acc);
    assign w_drop   = wr_en & full & ~w_rd_acc;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= r_mem[r_rd_ptr];
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + 1'b1;
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - 1'b1;
            end
            // A new drop outranks a clear in the same cycle
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign count    = r_count;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: hand-picked vectors checked against
// explicit expected values and a small queue reference.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       rd_en;
    logic       ovr_clr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       irq;

    int errors = 0;
    int checks = 0;

    logic [7:0] q [$];
    logic [7:0] m_rd;
    logic       m_ovr;

    uart_rx_fifo #(.DEPTH(16), .AW(4), .THRESH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .ovr_clr  (ovr_clr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overrun  (overrun),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic we, input logic [7:0] wd,
                       input logic re, input logic oc);
        bit rv;
        bit wa;
        int n;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        ovr_clr = oc;
        n  = q.size();
        rv = re && (n > 0);
        wa = we && ((n < 16) || rv);
        if (rv) m_rd = q.pop_front();
        if (wa) q.push_back(wd);
        if (we && !wa) m_ovr = 1'b1;
        else if (oc) m_ovr = 1'b0;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        ovr_clr = 1'b0;
        chk("rd_valid", rd_valid, rv);
        chk("rd_data", rd_data, m_rd);
        chk("count", count, q.size());
        chk("overrun", overrun, m_ovr);
        chk("empty", empty, q.size() == 0);
        chk("full", full, q.size() == 16);
        chk("irq", irq, q.size() >= 8);
    endtask

    initial begin
        rst = 1'b1; wr_en = 0; rd_en = 0; ovr_clr = 0; wr_data = 0;
        m_rd = 8'h00; m_ovr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_irq", irq, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_rdata", rd_data, 8'h00);
        chk("rst_rvalid", rd_valid, 0);
        rst = 1'b0;

        // two bytes in, two out
        cyc(1, 8'hA5, 0, 0);
        cyc(1, 8'h3C, 0, 0);
        chk("t33_cnt2", count, 2);
        cyc(0, 8'h00, 1, 0);
        chk("t33_d0", rd_data, 8'hA5);
        chk("t33_cnt1", count, 1);
        cyc(0, 8'h00, 1, 0);
        chk("t33_d1", rd_data, 8'h3C);
        chk("t33_empty", empty, 1);
        cyc(0, 8'h00, 0, 0);
        chk("t33_hold", rd_data, 8'h3C);
        chk("t33_novalid", rd_valid, 0);

        // fill, overflow, drain
        for (int i = 0; i < 16; i++) begin
            cyc(1, 8'(i), 0, 0);
            chk("t34_irq", irq, (i + 1) >= 8);
        end
        chk("t34_full", full, 1);
        chk("t34_cnt16", count, 16);
        cyc(1, 8'hFF, 0, 0);
        chk("t34_ovr", overrun, 1);
        chk("t34_cnt_drop", count, 16);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 8'h00, 1, 0);
            chk("t34_rd", rd_data, 8'(i));
        end
        chk("t34_empty", empty, 1);
        chk("t34_ovr_sticky", overrun, 1);
        cyc(0, 8'h00, 0, 1);
        chk("t34_ovr_clr", overrun, 0);

        // simultaneous write and read while full
        for (int i = 0; i < 16; i++) cyc(1, 8'(8'h10 + i), 0, 0);
        cyc(1, 8'h77, 1, 0);
        chk("t35_ovr", overrun, 0);
        chk("t35_cnt", count, 16);
        chk("t35_oldest", rd_data, 8'h10);
        for (int i = 1; i < 16; i++) begin
            cyc(0, 8'h00, 1, 0);
            chk("t35_rd", rd_data, 8'(8'h10 + i));
        end
        cyc(0, 8'h00, 1, 0);
        chk("t35_last", rd_data, 8'h77);

        // reads while empty
        cyc(0, 8'h00, 1, 0);
        chk("t36_novalid", rd_valid, 0);
        chk("t36_hold", rd_data, 8'h77);
        chk("t36_cnt0", count, 0);
        cyc(1, 8'h42, 1, 0);
        chk("t36_cnt1", count, 1);
        chk("t36_novalid2", rd_valid, 0);
        cyc(0, 8'h00, 1, 0);
        chk("t36_rd", rd_data, 8'h42);

        // 40-byte stream with interleaved reads, wrapping the pointers
        for (int i = 0; i < 40; i++) begin
            cyc(1, 8'(8'h80 + i), (q.size() >= 4) || ((i % 3) == 0), 0);
            chk("t37_range", (count >= 1) && (count <= 5), 1);
        end
        while (q.size() > 0) cyc(0, 8'h00, 1, 0);
        chk("t37_last", rd_data, 8'hA7);
        chk("t37_ovr", overrun, 0);

        // reset mid-write with overrun set
        for (int i = 0; i < 17; i++) cyc(1, 8'(8'hC0 + i), 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 8'h00, 1, 0);
        chk("t38_cnt10", count, 10);
        chk("t38_ovr_set", overrun, 1);
        wr_en = 1'b1; wr_data = 8'h55; rd_en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("t38_async_cnt", count, 0);
        chk("t38_async_empty", empty, 1);
        chk("t38_async_ovr", overrun, 0);
        chk("t38_async_rdata", rd_data, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0; wr_en = 0; rd_en = 0;
        q.delete(); m_rd = 8'h00; m_ovr = 1'b0;
        chk("t38_cnt", count, 0);
        chk("t38_rvalid", rd_valid, 0);
        cyc(1, 8'h99, 0, 0);
        cyc(0, 8'h00, 1, 0);
        chk("t38_first", rd_data, 8'h99);

        // clear and drop in the same cycle: set wins
        for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0);
        cyc(1, 8'hEE, 0, 1);
        chk("t38_setwins", overrun, 1);
        cyc(0, 8'h00, 0, 1);
        chk("t38_clr", overrun, 0);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 8'h00, 1, 0);
            chk("t38_drain", rd_data, 8'(i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
